// File: rtl/irq_controller_pkg.sv
// rtl/irq_controller_pkg.sv - shared SoC definitions for the interrupt controller
package irq_controller_pkg;

  localparam logic [4:0] ADDR_MASK   = 5'b11000;
  localparam logic [4:0] ADDR_PEND   = 5'b11001;
  localparam logic [4:0] ADDR_EPC    = 5'b11010;
  localparam logic [4:0] ADDR_STATUS = 5'b11011;
  localparam logic [4:0] ADDR_CTRL   = 5'b11100;

  localparam int WAIT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_TAKE    = 2'd2,
    ST_SERVICE = 2'd3
  } irq_state_e;

  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/irq_controller_prio_enc.sv
// rtl/irq_controller_prio_enc.sv - lowest-index-wins priority encoder (irq_prio_enc)
module irq_prio_enc #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  active_i,
  output logic          valid_o,
  output logic [IW-1:0] index_o
);

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    valid_o = |active_i;
    index_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (active_i[i]) index_o = IW'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - edge-latched interrupt controller with hold handshake and MMIO
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int NSRC     = 4,
  parameter int HOLD_TMO = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_src,
  input  logic            hold_ack,
  input  logic            intctrl,
  input  logic            eret,
  input  logic [31:0]     pc_current,
  input  logic            we,
  input  logic [4:0]      addr,
  input  logic [31:0]     wd,
  output logic            hold,
  output logic            exl,
  output logic            iv,
  output logic [31:0]     epc,
  output logic [31:0]     rd
);

  localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

  irq_state_e        state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [NSRC-1:0]   prev_q;
  logic [NSRC-1:0]   pending_q, pending_d;
  logic [NSRC-1:0]   mask_q, mask_d;
  logic              ctrl_q, ctrl_d;
  logic [31:0]       epc_q, epc_d;
  logic [3:0]        cause_q, cause_d;
  logic              exl_q, exl_d;

  logic [NSRC-1:0]   src_rise;
  logic [NSRC-1:0]   w1c;
  logic [NSRC-1:0]   active;
  logic              win_valid;
  logic [IW-1:0]     win_idx;
  logic              unused_wd;

  assign unused_wd = ^wd[31:NSRC];

  irq_prio_enc #(.N(NSRC), .IW(IW)) u_prio (
    .active_i (active),
    .valid_o  (win_valid),
    .index_o  (win_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      ctrl_q    <= 1'b0;
      epc_q     <= '0;
      cause_q   <= '0;
      exl_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prev_q    <= irq_src;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      ctrl_q    <= ctrl_d;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
      exl_q     <= exl_d;
    end
  end

  // A new edge is ORed in after the clear so set wins a same-cycle W1C.
  assign src_rise  = irq_src & ~prev_q;
  assign w1c       = (we && addr == ADDR_PEND) ? wd[NSRC-1:0] : '0;
  assign pending_d = (pending_q & ~w1c) | src_rise;
  assign mask_d    = (we && addr == ADDR_MASK) ? wd[NSRC-1:0] : mask_q;
  assign ctrl_d    = (we && addr == ADDR_CTRL) ? wd[0] : ctrl_q;
  assign active    = pending_q & mask_q;
  assign cnt_inc   = sat_inc(cnt_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    exl_d   = exl_q;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d = ST_REQ;
          cnt_d   = '0;
        end
      end
      ST_REQ: begin
        if (!win_valid) begin
          state_d = ST_IDLE;
        end else if (hold_ack && !intctrl) begin
          state_d = ST_TAKE;
        end else if (cnt_inc == WAIT_W'(HOLD_TMO)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_TAKE: begin
        epc_d   = pc_current;
        cause_d = 4'(win_idx);
        exl_d   = 1'b1;
        state_d = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (eret) begin
          exl_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd = '0;
    case (addr)
      ADDR_MASK:   rd[NSRC-1:0] = mask_q;
      ADDR_PEND:   rd[NSRC-1:0] = pending_q;
      ADDR_EPC:    rd           = epc_q;
      ADDR_STATUS: rd[6:0]      = {cause_q, state_q, exl_q};
      ADDR_CTRL:   rd[0]        = ctrl_q;
      default:     rd           = '0;
    endcase
  end

  assign hold = (state_q == ST_REQ);
  assign exl  = exl_q;
  assign iv   = ctrl_q & exl_q;
  assign epc  = epc_q;

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - randomized and directed bench for irq_controller against a behavioural model
module tb_irq_controller;

  localparam int NSRC = 4;
  localparam int TMO  = 16;
  localparam logic [4:0] A_MASK = 5'b11000;
  localparam logic [4:0] A_PEND = 5'b11001;
  localparam logic [4:0] A_EPC  = 5'b11010;
  localparam logic [4:0] A_STAT = 5'b11011;
  localparam logic [4:0] A_CTRL = 5'b11100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  irq_src = '0;
  logic        hold_ack = 1'b0, intctrl = 1'b0, eret = 1'b0, we = 1'b0;
  logic [31:0] pc_current = '0, wd = '0;
  logic [4:0]  addr = A_STAT;
  logic        hold, exl, iv;
  logic [31:0] epc, rd;

  int n_chk = 0;
  int n_err = 0;

  // Model: mode 0 idle, 1 waiting for decoder, 2 taking, 3 in handler.
  int          m_mode, m_wait;
  logic [3:0]  m_prev, m_pend, m_mask, m_cause;
  logic        m_ctrl, m_exl;
  logic [31:0] m_epc;

  irq_controller #(.NSRC(NSRC), .HOLD_TMO(TMO)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .hold_ack(hold_ack),
    .intctrl(intctrl), .eret(eret), .pc_current(pc_current), .we(we),
    .addr(addr), .wd(wd), .hold(hold), .exl(exl), .iv(iv), .epc(epc), .rd(rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    case (a)
      A_MASK:  return {28'd0, m_mask};
      A_PEND:  return {28'd0, m_pend};
      A_EPC:   return m_epc;
      A_STAT:  return {25'd0, m_cause, 2'(m_mode), m_exl};
      A_CTRL:  return {31'd0, m_ctrl};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_wait = 0; m_prev = '0; m_pend = '0; m_mask = '0;
    m_cause = '0; m_ctrl = 1'b0; m_exl = 1'b0; m_epc = '0;
  endtask

  task automatic model_step();
    int         win;
    logic [3:0] act, clr;
    win = -1;
    act = m_pend & m_mask;
    for (int i = 0; i < NSRC; i++) if (act[i] && win < 0) win = i;
    clr = (we && addr == A_PEND) ? wd[3:0] : 4'd0;
    case (m_mode)
      0: if (win >= 0) begin m_mode = 1; m_wait = 0; end
      1: begin
        if (win < 0) m_mode = 0;
        else if (hold_ack && !intctrl) m_mode = 2;
        else begin
          m_wait++;
          if (m_wait >= TMO) m_mode = 0;
        end
      end
      2: begin
        m_epc = pc_current;
        m_cause = (win < 0) ? 4'd0 : 4'(win);
        m_exl = 1'b1;
        m_mode = 3;
      end
      default: if (eret) begin m_exl = 1'b0; m_mode = 0; end
    endcase
    m_pend = (m_pend & ~clr) | (irq_src & ~m_prev);
    m_prev = irq_src;
    if (we && addr == A_MASK) m_mask = wd[3:0];
    if (we && addr == A_CTRL) m_ctrl = wd[0];
  endtask

  // Called at posedge+1; checks against the model at negedge, then advances one cycle.
  task automatic step();
    @(negedge clk);
    check("hold", {31'd0, hold}, {31'd0, m_mode == 1});
    check("exl", {31'd0, exl}, {31'd0, m_exl});
    check("iv", {31'd0, iv}, {31'd0, m_exl & m_ctrl});
    check("epc", epc, m_epc);
    check("rd", rd, m_rd(addr));
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hold_ack = 0; intctrl = 0; eret = 0; we = 0; wd = '0; addr = A_STAT;
  endtask

  task automatic mmio_wr(input logic [4:0] a, input logic [31:0] d);
    we = 1; addr = a; wd = d;
    step();
    we = 0; addr = A_STAT; wd = '0;
  endtask

  task automatic do_reset();
    irq_src = '0;
    idle_inputs();
    addr = A_PEND;
    rst = 1;
    #1;
    check("rst_hold", {31'd0, hold}, 32'd0);
    check("rst_exl", {31'd0, exl}, 32'd0);
    check("rst_pend_rd", rd, 32'd0);
    check("rst_epc", epc, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    addr = A_STAT;
  endtask

  task automatic wait_hold(input string tag);
    int n = 0;
    while (!hold && n < 40) begin step(); n++; end
    check(tag, {31'd0, hold}, 32'd1);
  endtask

  task automatic take_and_enter();
    hold_ack = 1; step();
    hold_ack = 0; step();
  endtask

  logic [4:0] addr_tab [5] = '{A_MASK, A_PEND, A_EPC, A_STAT, A_CTRL};

  initial begin
    int n_hi, n_lo;
    #3;
    do_reset();

    // Single source entry with a two-cycle acknowledge delay.
    mmio_wr(A_MASK, 32'h1);
    pc_current = 32'h40;
    irq_src = 4'b0001; step();
    wait_hold("t034_hold");
    step(); step();
    hold_ack = 1; step();
    check("t034_exl_in_take", {31'd0, exl}, 32'd0);
    hold_ack = 0; step();
    check("t034_exl", {31'd0, exl}, 32'd1);
    check("t034_hold_low", {31'd0, hold}, 32'd0);
    check("t034_epc", epc, 32'h40);
    addr = A_STAT; #1;
    check("t034_cause", {28'd0, rd[6:3]}, 32'd0);
    eret = 1; step(); eret = 0;
    check("t034_eret_exl", {31'd0, exl}, 32'd0);

    // Simultaneous sources: lowest wins, then the other after W1C.
    do_reset();
    mmio_wr(A_MASK, 32'hF);
    irq_src = 4'b0110; step();
    wait_hold("t035_hold1");
    take_and_enter();
    addr = A_STAT; #1;
    check("t035_cause1", {28'd0, rd[6:3]}, 32'd1);
    eret = 1; we = 1; addr = A_PEND; wd = 32'h2; step();
    idle_inputs();
    wait_hold("t035_hold2");
    take_and_enter();
    addr = A_STAT; #1;
    check("t035_cause2", {28'd0, rd[6:3]}, 32'd2);

    // Hold timeout and re-request.
    do_reset();
    mmio_wr(A_MASK, 32'h1);
    irq_src = 4'b0001; step();
    wait_hold("t036_hold");
    n_hi = 0;
    while (hold && n_hi < 40) begin n_hi++; step(); end
    check("t036_high_cycles", n_hi, TMO);
    n_lo = 0;
    while (!hold && n_lo < 40) begin n_lo++; step(); end
    check("t036_low_ge1", {31'd0, n_lo >= 1}, 32'd1);
    check("t036_reassert", {31'd0, hold}, 32'd1);

    // Branch in flight blocks entry even with acknowledge.
    do_reset();
    mmio_wr(A_MASK, 32'h1);
    irq_src = 4'b0001; step();
    wait_hold("t037_hold");
    hold_ack = 1; intctrl = 1;
    for (int k = 0; k < 3; k++) begin
      pc_current = 32'h100 + k; step();
      check("t037_no_exl", {31'd0, exl}, 32'd0);
      check("t037_keep_hold", {31'd0, hold}, 32'd1);
    end
    intctrl = 0; pc_current = 32'h1234; step();
    hold_ack = 0; step();
    check("t037_exl", {31'd0, exl}, 32'd1);
    check("t037_epc", epc, 32'h1234);

    // Edge set beats same-cycle W1C; plain W1C clears.
    do_reset();
    irq_src = 4'b0001; step();
    irq_src = 4'b0000; step();
    addr = A_PEND; #1;
    check("t038_set", rd, 32'h1);
    irq_src = 4'b0001; we = 1; addr = A_PEND; wd = 32'h1; step();
    we = 0; #1;
    check("t038_set_wins", rd, 32'h1);
    we = 1; wd = 32'h1; step();
    we = 0; #1;
    check("t038_clear", rd, 32'h0);

    // Reset during the handler.
    do_reset();
    mmio_wr(A_CTRL, 32'h1);
    mmio_wr(A_MASK, 32'h1);
    irq_src = 4'b0001; step();
    wait_hold("t039_hold");
    take_and_enter();
    check("t039_exl", {31'd0, exl}, 32'd1);
    check("t039_iv", {31'd0, iv}, 32'd1);
    do_reset();
    check("t039_iv_after", {31'd0, iv}, 32'd0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      for (int b = 0; b < NSRC; b++)
        if ($urandom_range(0, 7) == 0) irq_src[b] = ~irq_src[b];
      hold_ack   = ($urandom_range(0, 2) == 0);
      intctrl    = ($urandom_range(0, 3) == 0);
      eret       = ($urandom_range(0, 5) == 0);
      we         = ($urandom_range(0, 4) == 0);
      wd         = $urandom;
      pc_current = $urandom;
      if ($urandom_range(0, 5) == 0) addr = 5'($urandom);
      else addr = addr_tab[$urandom_range(0, 4)];
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
